// File: rtl/fib_matpow_ctrl_pkg.sv
// Shared definitions for the Fibonacci matrix-power controller: FSM states and
// the constant matrices used to seed the accumulator and the base.
package fib_matpow_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_TEST = 3'd1,
      ST_MULR = 3'd2,
      ST_SQR  = 3'd3,
      ST_FIN  = 3'd4
   } state_e;

   // Element order is {x00, x01, x10, x11}; every element is 0 or 1.
   localparam logic [3:0] IDENT_BITS = 4'b1001;
   localparam logic [3:0] Q_BITS     = 4'b1110;

   localparam int unsigned MAT_ELEMS = 4;

   // Position of element k (0=x00 .. 3=x11) inside the packed constants above.
   function automatic int unsigned elem_bit(input int unsigned k);
      return MAT_ELEMS - 1 - k;
   endfunction

endpackage

// File: rtl/fib_matpow_ctrl_if.sv
// Start/done coprocessor handshake between the CPU side (master) and the
// Fibonacci controller (slave).
interface fib_matpow_ctrl_if #(
   parameter int W  = 32,
   parameter int NW = 32
) ();

   logic          start;
   logic [NW-1:0] n;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;

   modport master (
      output start,
      output n,
      input  busy,
      input  done,
      input  result
   );

   modport slave (
      input  start,
      input  n,
      output busy,
      output done,
      output result
   );

endinterface

// File: rtl/fib_matpow_ctrl_mat2_mul.sv
// Combinational 2x2 matrix product C = A*B; every element wraps mod 2^W.
module mat2_mul #(
   parameter int W = 32
) (
   input  logic [W-1:0] a00,
   input  logic [W-1:0] a01,
   input  logic [W-1:0] a10,
   input  logic [W-1:0] a11,
   input  logic [W-1:0] b00,
   input  logic [W-1:0] b01,
   input  logic [W-1:0] b10,
   input  logic [W-1:0] b11,
   output logic [W-1:0] c00,
   output logic [W-1:0] c01,
   output logic [W-1:0] c10,
   output logic [W-1:0] c11
);

   // Operands are W bits wide, so each product and sum truncates to W bits.
   assign c00 = a00 * b00 + a01 * b10;
   assign c01 = a00 * b01 + a01 * b11;
   assign c10 = a10 * b00 + a11 * b10;
   assign c11 = a10 * b01 + a11 * b11;

endmodule

// File: rtl/fib_matpow_ctrl.sv
// Computes F(n) mod 2^W as element [1][0] of Q^n by square-and-multiply,
// sharing one 2x2 multiplier between the R*M and M*M steps.
module fib_matpow_ctrl
   import fib_matpow_ctrl_pkg::*;
#(
   parameter int W  = 32,
   parameter int NW = 32
) (
   input  logic               clk,
   input  logic               reset,
   fib_matpow_ctrl_if.slave   bus
);

   state_e        state_q, state_d;
   logic [NW-1:0] e_q, e_d;
   logic [W-1:0]  r_q [MAT_ELEMS];
   logic [W-1:0]  r_d [MAT_ELEMS];
   logic [W-1:0]  m_q [MAT_ELEMS];
   logic [W-1:0]  m_d [MAT_ELEMS];
   logic [W-1:0]  a_op [MAT_ELEMS];
   logic [W-1:0]  prod [MAT_ELEMS];
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [W-1:0]  result_q, result_d;

   // Left operand is R while multiplying into the accumulator, otherwise M.
   generate
      for (genvar gi = 0; gi < MAT_ELEMS; gi++) begin : g_op_mux
         assign a_op[gi] = (state_q == ST_MULR) ? r_q[gi] : m_q[gi];
      end
   endgenerate

   mat2_mul #(.W(W)) u_mul (
      .a00 (a_op[0]),
      .a01 (a_op[1]),
      .a10 (a_op[2]),
      .a11 (a_op[3]),
      .b00 (m_q[0]),
      .b01 (m_q[1]),
      .b10 (m_q[2]),
      .b11 (m_q[3]),
      .c00 (prod[0]),
      .c01 (prod[1]),
      .c10 (prod[2]),
      .c11 (prod[3])
   );

   always_comb begin
      state_d  = state_q;
      e_d      = e_q;
      r_d      = r_q;
      m_d      = m_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               e_d     = bus.n;
               busy_d  = 1'b1;
               state_d = ST_TEST;
               for (int unsigned k = 0; k < MAT_ELEMS; k++) begin
                  r_d[k] = {{(W-1){1'b0}}, IDENT_BITS[elem_bit(k)]};
                  m_d[k] = {{(W-1){1'b0}}, Q_BITS[elem_bit(k)]};
               end
            end
         end
         ST_TEST: begin
            if (e_q == '0) begin
               state_d = ST_FIN;
            end else if (e_q[0]) begin
               state_d = ST_MULR;
            end else begin
               state_d = ST_SQR;
            end
         end
         ST_MULR: begin
            r_d     = prod;
            state_d = ST_SQR;
         end
         ST_SQR: begin
            // The last squaring is never used and may overflow; that is harmless.
            m_d     = prod;
            e_d     = e_q >> 1;
            state_d = ST_TEST;
         end
         ST_FIN: begin
            result_d = r_q[2];
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         e_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         for (int unsigned k = 0; k < MAT_ELEMS; k++) begin
            r_q[k] <= '0;
            m_q[k] <= '0;
         end
      end else begin
         state_q  <= state_d;
         e_q      <= e_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         r_q      <= r_d;
         m_q      <= m_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule
